data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
// - Data-memory side of the EXECUTE load/store interface: takes the address, data, read and write strobes that EXECUTE drives
//   and returns registered read data for the WRITE stage.
// - Single-port synchronous RAM of 2**ADDRESS_SIZE words.
// - Hardware zero-fill sequencer runs after reset and on i_clear request.
// PARAMETERS
// - ADDRESS_SIZE  10  word-address width; DEPTH = 2**ADDRESS_SIZE words
// - DATA_SIZE     32  word width in bits
// PORTS
// - i_clk          in   1             single clock, all state updates on rising edge
// - i_rst_n        in   1             asynchronous, active-low reset
// - i_read         in   1             read request; sampled on the edge
// - i_write        in   1             write request; sampled on the edge
// - i_address      in   ADDRESS_SIZE  word address of the request
// - i_data         in   DATA_SIZE     write data
// - i_clear        in   1             request a zero-fill of the whole array
// - o_data         out  DATA_SIZE     registered read data
// - o_data_valid   out  1             o_data updated by a read on the previous edge; 1-cycle pulse
// - o_ready        out  1             1 = requests accepted; 0 = zero-fill in progress
// - o_error        out  1             1-cycle pulse: i_read and i_write were both high in READY
// BEHAVIOUR
// - Clock and reset: one clock. Reset is asynchronous and active-low.
// - Reset values: o_data=0, o_data_valid=0, o_ready=0, o_error=0, state=CLEAR, clr_cnt=0.
// - Reset asserted at any time, including mid-fill, aborts the current operation. The zero-fill restarts at address 0 after release.
// - FSM, two states:
//   - CLEAR: each edge writes 0 to mem[clr_cnt], then clr_cnt++.
//     - On the edge that writes DEPTH-1: state->READY, o_ready->1. Exactly DEPTH CLEAR cycles.
//     - i_read, i_write and i_clear are ignored in CLEAR: no RAM write, o_data_valid=0, o_error=0.
//     - clr_cnt is ADDRESS_SIZE+1 bits wide, so the last-address compare cannot wrap.
//   - READY:
//     - i_clear=1: state->CLEAR, clr_cnt->0, o_ready->0 on that edge. A read or write in the same cycle is dropped.
//     - write only: mem[i_address]<=i_data on the edge.
//     - read only: o_data<=mem[i_address] on the edge and o_data_valid=1 for that cycle. Latency is one edge, so data meets WRITE-stage timing.
//     - read and write together: the write is performed and the read is dropped. o_error=1 and o_data_valid=0 for one cycle; o_data holds.
//     - no request: o_data holds its last value; o_data_valid=0.
// - Read-after-write: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
//   Within a single edge the RAM is read-before-write, which matters only for the dropped-read case above.
// - Back-to-back reads are accepted every cycle with no bubbles; o_data_valid stays high.
// - Full-range addressing, no bounds errors; address DEPTH-1 then 0 needs no special handling.
// - Widths: no arithmetic on data. o_data is the exact stored word; no sign handling.
// STRUCTURE
// - core_defines.vh gains:
//   - state encodings `DM_CLEAR=1'b0, `DM_READY=1'b1
//   - `DM_LEN=1 (state width)
// - Sub-module dm_sync_ram(ADDRESS_SIZE, DATA_SIZE): one write port (we, waddr, wdata) and one registered read port (re, raddr, rdata); no reset on the array.
// - Top level: FSM, clr_cnt, write-port mux (fill vs request), valid/error flops.
// TESTING (bench uses ADDRESS_SIZE=4, DEPTH=16)
// - Release reset, no requests -> o_ready=0 for 16 edges, 1 after the 16th; reads of addr 0..15 all return 0 with o_data_valid=1.
// - Write 32'hDEADBEEF @5, then read @5 on the next cycle -> o_data=32'hDEADBEEF, o_data_valid=1 for exactly one cycle.
// - Write 32'h12345678 @3, then read and write 32'hA5A5A5A5 @3 in the same cycle -> o_error=1 for 1 cycle, o_data_valid=0, o_data unchanged; a later read @3 returns 32'hA5A5A5A5.
// - Pulse i_clear in READY with write @7 in the same cycle -> o_ready=0 for 16 cycles; write 32'hFF @9 during the fill is ignored; afterwards reads @5, @7, @9 return 0.
// - Assert i_rst_n=0 at fill cycle 8 -> all outputs reset immediately; after release o_ready rises after 16 more edges.
// - Write addr+1 to addr 0..15, then back-to-back reads of 15,0,1..14 -> o_data_valid continuously high; o_data = 16,1,2..15, each one cycle after its request.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared state encoding for the data-memory responder
package data_memory_responder_pkg;

  localparam int DM_LEN = 1;

  typedef enum logic [DM_LEN-1:0] {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

endpackage

// File: rtl/dm_sync_ram.sv
// rtl/dm_sync_ram.sv - single-clock RAM, one write port, one registered read port
module dm_sync_ram #(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDRESS_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0]    wdata,
  input  logic                    re,
  input  logic [ADDRESS_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

  // The array carries no reset; contents are defined by the zero-fill sequencer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register resets, so rdata is 0 until the first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - load/store data memory with hardware zero-fill sequencer
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_read,
  input  logic                    i_write,
  input  logic [ADDRESS_SIZE-1:0] i_address,
  input  logic [DATA_SIZE-1:0]    i_data,
  input  logic                    i_clear,
  output logic [DATA_SIZE-1:0]    o_data,
  output logic                    o_data_valid,
  output logic                    o_ready,
  output logic                    o_error
);

  localparam logic [ADDRESS_SIZE:0] LAST_ADDR = (ADDRESS_SIZE + 1)'((1 << ADDRESS_SIZE) - 1);

  dm_state_t               state, next_state;
  logic [ADDRESS_SIZE:0]   clr_cnt, clr_cnt_next;
  logic                    ram_we, ram_re, error_next;
  logic [ADDRESS_SIZE-1:0] ram_waddr;
  logic [DATA_SIZE-1:0]    ram_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= DM_CLEAR;
      clr_cnt      <= '0;
      o_data_valid <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      state        <= next_state;
      clr_cnt      <= clr_cnt_next;
      o_data_valid <= ram_re;
      o_error      <= error_next;
    end
  end

  // The write port is shared: the fill sequencer owns it in CLEAR, requests own it in READY.
  always_comb begin
    next_state   = state;
    clr_cnt_next = clr_cnt;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = i_address;
    ram_wdata    = i_data;
    error_next   = 1'b0;
    case (state)
      DM_CLEAR: begin
        ram_we       = 1'b1;
        ram_waddr    = clr_cnt[ADDRESS_SIZE-1:0];
        ram_wdata    = '0;
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          next_state = DM_READY;
        end
      end
      DM_READY: begin
        if (i_clear) begin
          next_state   = DM_CLEAR;
          clr_cnt_next = '0;
        end else begin
          // A simultaneous read and write keeps the write and reports the collision.
          ram_we     = i_write;
          ram_re     = i_read && !i_write;
          error_next = i_read && i_write;
        end
      end
    endcase
  end

  assign o_ready = (state == DM_READY);

  dm_sync_ram #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .DATA_SIZE   (DATA_SIZE)
  ) u_ram (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(i_address),
    .rdata(o_data)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench against a behavioural memory model
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] o_data;
  logic        o_data_valid, o_ready, o_error;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_mem [16];
  bit          m_ready;
  int          m_fill;
  logic [31:0] m_data;
  bit          m_valid, m_error;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDRESS_SIZE(4), .DATA_SIZE(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_read      (rd),
    .i_write     (wr),
    .i_address   (addr),
    .i_data      (wdata),
    .i_clear     (clr),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_ready     (o_ready),
    .o_error     (o_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_fill  = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_error = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit w, input bit c, input int a, input logic [31:0] d);
    m_valid = 1'b0;
    m_error = 1'b0;
    if (!m_ready) begin
      m_mem[m_fill] = '0;
      m_fill++;
      if (m_fill == 16) m_ready = 1'b1;
    end else if (c) begin
      m_ready = 1'b0;
      m_fill  = 0;
    end else if (r && w) begin
      m_mem[a] = d;
      m_error  = 1'b1;
    end else if (w) begin
      m_mem[a] = d;
    end else if (r) begin
      m_data  = m_mem[a];
      m_valid = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"}, 32'(o_ready), 32'(m_ready));
    check({tag, ".valid"}, 32'(o_data_valid), 32'(m_valid));
    check({tag, ".error"}, 32'(o_error), 32'(m_error));
    check({tag, ".data"}, o_data, m_data);
  endtask

  task automatic step(input string tag, input bit r, input bit w, input bit c,
                      input logic [3:0] a, input logic [31:0] d);
    rd = r; wr = w; clr = c; addr = a; wdata = d;
    @(posedge clk);
    model_edge(r, w, c, int'(a), d);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 32'hBAD0_0000 | i;
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle("fill", 16);
    for (int i = 0; i < 16; i++) step("zero_read", 1'b1, 1'b0, 1'b0, 4'(i), 32'd0);

    step("wr5", 1'b0, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF);
    step("rd5", 1'b1, 1'b0, 1'b0, 4'd5, 32'd0);
    check("rd5.value", o_data, 32'hDEADBEEF);
    idle("after_rd5", 1);

    step("wr3", 1'b0, 1'b1, 1'b0, 4'd3, 32'h12345678);
    step("rdwr3", 1'b1, 1'b1, 1'b0, 4'd3, 32'hA5A5A5A5);
    idle("after_err", 1);
    step("rd3", 1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
    check("rd3.value", o_data, 32'hA5A5A5A5);

    step("wr7", 1'b0, 1'b1, 1'b0, 4'd7, 32'h00000077);
    step("clr_wr7", 1'b0, 1'b1, 1'b1, 4'd7, 32'h11111111);
    for (int i = 0; i < 16; i++)
      step("refill", 1'b0, i == 4, 1'b0, 4'd9, 32'h000000FF);
    step("rd5z", 1'b1, 1'b0, 1'b0, 4'd5, 32'd0);
    step("rd7z", 1'b1, 1'b0, 1'b0, 4'd7, 32'd0);
    step("rd9z", 1'b1, 1'b0, 1'b0, 4'd9, 32'd0);
    check("rd9z.value", o_data, 32'd0);

    step("clr2", 1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
    idle("partfill", 8);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midfill_reset");
    @(posedge clk); #1;
    check_outputs("reset_held");
    rst_n = 1'b1;
    idle("fill2", 16);

    for (int i = 0; i < 16; i++) step("wr_seq", 1'b0, 1'b1, 1'b0, 4'(i), 32'(i + 1));
    step("b2b", 1'b1, 1'b0, 1'b0, 4'd15, 32'd0);
    check("b2b.first", o_data, 32'd16);
    for (int i = 0; i < 15; i++) step("b2b", 1'b1, 1'b0, 1'b0, 4'(i), 32'd0);
    check("b2b.last", o_data, 32'd15);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), 1'($urandom), ($urandom_range(0, 40) == 0),
           4'($urandom), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
